// File: rtl/phase1_control_sequencer.sv
// Control sequencer for the phase-1 datapath: fetches one instruction per start pulse
// and runs a register-register ALU execute, driving bus selects, load enables and ALU opcode.
module phase1_control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter logic [4:0]  MUL_OPCODE  = 5'b01111,
    parameter logic [4:0]  DIV_OPCODE  = 5'b10000,
    parameter logic [4:0]  ALU_OP_MIN  = 5'b00011,
    parameter logic [4:0]  ALU_OP_MAX  = 5'b10000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir_in,
    input  logic        mem_done,
    output logic [31:0] bus_select,
    output logic [15:0] reg_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        hi_enable,
    output logic        lo_enable,
    output logic        pc_enable,
    output logic        mar_enable,
    output logic        mdr_enable,
    output logic        ir_enable,
    output logic        read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, FIN
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = MEM_TIMEOUT[7:0];

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_bits;

    assign op             = ir_in[31:27];
    assign ra             = ir_in[26:23];
    assign rb             = ir_in[22:19];
    assign rc             = ir_in[18:15];
    assign unused_ir_bits = ^ir_in[14:0];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        bus_select = '0;
        reg_enable = '0;
        y_enable   = 1'b0;
        z_enable   = 1'b0;
        hi_enable  = 1'b0;
        lo_enable  = 1'b0;
        pc_enable  = 1'b0;
        mar_enable = 1'b0;
        mdr_enable = 1'b0;
        ir_enable  = 1'b0;
        read       = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = '0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        error      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = T0;
            end
            T0: begin
                bus_select[20] = 1'b1;
                mar_enable     = 1'b1;
                inc_pc         = 1'b1;
                z_enable       = 1'b1;
                wait_cnt_d     = '0;
                state_d        = T1;
            end
            T1: begin
                read = 1'b1;
                // mem_done takes priority even on the final allowed wait cycle
                if (mem_done) begin
                    mdr_enable     = 1'b1;
                    bus_select[19] = 1'b1;
                    pc_enable      = 1'b1;
                    state_d        = T2;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            T2: begin
                bus_select[21] = 1'b1;
                ir_enable      = 1'b1;
                state_d        = T3;
            end
            T3: begin
                if (op < ALU_OP_MIN || op > ALU_OP_MAX) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    bus_select[rb] = 1'b1;
                    y_enable       = 1'b1;
                    state_d        = T4;
                end
            end
            T4: begin
                bus_select[rc] = 1'b1;
                alu_op         = op;
                z_enable       = 1'b1;
                state_d        = T5;
            end
            T5: begin
                bus_select[19] = 1'b1;
                if (op == MUL_OPCODE || op == DIV_OPCODE) begin
                    lo_enable = 1'b1;
                    state_d   = T6;
                end else begin
                    reg_enable[ra] = 1'b1;
                    state_d        = FIN;
                end
            end
            T6: begin
                bus_select[18] = 1'b1;
                hi_enable      = 1'b1;
                state_d        = FIN;
            end
            FIN: begin
                done    = 1'b1;
                error   = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_phase1_control_sequencer.sv
// Self-checking bench: builds the expected per-cycle output trace of each instruction
// from the sequencing rules and compares every cycle against the DUT.
module tb_phase1_control_sequencer;

    localparam int TO = 15;

    localparam logic [7:0] L_Y   = 8'h80;
    localparam logic [7:0] L_Z   = 8'h40;
    localparam logic [7:0] L_HI  = 8'h20;
    localparam logic [7:0] L_LO  = 8'h10;
    localparam logic [7:0] L_PC  = 8'h08;
    localparam logic [7:0] L_MAR = 8'h04;
    localparam logic [7:0] L_MDR = 8'h02;
    localparam logic [7:0] L_IR  = 8'h01;

    logic        clk = 1'b0;
    logic        clr, start, mem_done;
    logic [31:0] ir_in;
    logic [31:0] bus_select;
    logic [15:0] reg_enable;
    logic        y_enable, z_enable, hi_enable, lo_enable;
    logic        pc_enable, mar_enable, mdr_enable, ir_enable;
    logic        read, inc_pc, busy, done, error;
    logic [4:0]  alu_op;

    int checks = 0;
    int fails  = 0;

    logic [65:0] exp_q[$];
    string       tag_q[$];
    logic        md_q[$];
    int          t3_idx;

    phase1_control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .start(start), .ir_in(ir_in), .mem_done(mem_done),
        .bus_select(bus_select), .reg_enable(reg_enable),
        .y_enable(y_enable), .z_enable(z_enable), .hi_enable(hi_enable), .lo_enable(lo_enable),
        .pc_enable(pc_enable), .mar_enable(mar_enable), .mdr_enable(mdr_enable), .ir_enable(ir_enable),
        .read(read), .inc_pc(inc_pc), .alu_op(alu_op), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic logic [65:0] mk(input int bus, input logic [15:0] re, input logic [7:0] ld,
                                       input logic rd, input logic inc, input logic [4:0] alu,
                                       input logic bz, input logic dn, input logic er);
        logic [31:0] b;
        b = '0;
        if (bus >= 0) b[bus] = 1'b1;
        return {b, re, ld, rd, inc, alu, bz, dn, er};
    endfunction

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0};
    endfunction

    task automatic add_step(input logic [65:0] e, input string tag, input logic md);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        md_q.push_back(md);
    endtask

    // Expected trace for one instruction; w = T1 cycles without mem_done before it arrives
    task automatic build(input logic [31:0] ir, input int w);
        int          op, ra, rb, rc;
        logic [15:0] re;
        op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        exp_q.delete(); tag_q.delete(); md_q.delete();
        t3_idx = 1000;
        add_step(mk(20, '0, L_MAR | L_Z, 0, 1, '0, 1, 0, 0), "T0", 1'($urandom_range(0, 1)));
        for (int i = 0; i < w && i < TO; i++)
            add_step(mk(-1, '0, '0, 1, 0, '0, 1, 0, 0), "T1_wait", 1'b0);
        if (w >= TO) begin
            add_step(mk(-1, '0, '0, 0, 0, '0, 1, 1, 1), "FIN_timeout", 1'($urandom_range(0, 1)));
            return;
        end
        add_step(mk(19, '0, L_MDR | L_PC, 1, 0, '0, 1, 0, 0), "T1_done", 1'b1);
        add_step(mk(21, '0, L_IR, 0, 0, '0, 1, 0, 0), "T2", 1'($urandom_range(0, 1)));
        t3_idx = exp_q.size();
        if (op < 3 || op > 16) begin
            add_step(mk(-1, '0, '0, 0, 0, '0, 1, 0, 0), "T3_illegal", 1'($urandom_range(0, 1)));
            add_step(mk(-1, '0, '0, 0, 0, '0, 1, 1, 1), "FIN_illegal", 1'($urandom_range(0, 1)));
            return;
        end
        add_step(mk(rb, '0, L_Y, 0, 0, '0, 1, 0, 0), "T3", 1'($urandom_range(0, 1)));
        add_step(mk(rc, '0, L_Z, 0, 0, 5'(op), 1, 0, 0), "T4", 1'($urandom_range(0, 1)));
        if (op == 15 || op == 16) begin
            add_step(mk(19, '0, L_LO, 0, 0, '0, 1, 0, 0), "T5_lo", 1'($urandom_range(0, 1)));
            add_step(mk(18, '0, L_HI, 0, 0, '0, 1, 0, 0), "T6_hi", 1'($urandom_range(0, 1)));
        end else begin
            re = '0;
            re[ra] = 1'b1;
            add_step(mk(19, re, '0, 0, 0, '0, 1, 0, 0), "T5_wb", 1'($urandom_range(0, 1)));
        end
        add_step(mk(-1, '0, '0, 0, 0, '0, 1, 1, 0), "FIN", 1'($urandom_range(0, 1)));
    endtask

    task automatic check(input logic [65:0] e, input string tag);
        logic [65:0] o;
        o = {bus_select, reg_enable, y_enable, z_enable, hi_enable, lo_enable,
             pc_enable, mar_enable, mdr_enable, ir_enable, read, inc_pc, alu_op,
             busy, done, error};
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // smode: 0 start low while busy, 1 random, 2 held high; abort_at: trace index where clr is raised
    task automatic run(input logic [31:0] ir, input int w, input int smode, input int abort_at);
        build(ir, w);
        @(negedge clk);
        clr = 1'b0; start = 1'b1; ir_in = $urandom; mem_done = 1'($urandom_range(0, 1));
        #1 check('0, "IDLE_pre");
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start    = (smode == 0) ? 1'b0 : (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            mem_done = md_q[i];
            ir_in    = (i >= t3_idx) ? ir : $urandom;
            if (i == abort_at) begin
                clr   = 1'b1;
                start = 1'b1;
            end
            #1 check(exp_q[i], tag_q[i]);
            if (i == abort_at) break;
        end
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        #1 check('0, "IDLE_post");
        if (abort_at >= 0) begin
            @(negedge clk);
            #1 check('0, "IDLE_post_abort");
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; mem_done = 1'b0; ir_in = '0;
        @(negedge clk); start = 1'b1;
        #1 check('0, "reset_0");
        @(negedge clk);
        #1 check('0, "reset_1");
        @(negedge clk); clr = 1'b0; start = 1'b0;
        #1 check('0, "reset_2");

        run(32'h18918000, 0, 0, -1);
        run(enc(15, 6, 4, 5), 0, 0, -1);
        run(enc(16, 2, 9, 15), 0, 0, -1);
        run(enc(3, 0, 0, 0), 3, 0, -1);
        run(enc(4, 7, 7, 7), TO - 1, 0, -1);
        run(enc(4, 7, 7, 7), 1000, 0, -1);
        run(enc(0, 1, 2, 3), 0, 0, -1);
        run(enc(2, 1, 2, 3), 0, 1, -1);
        run(enc(17, 1, 2, 3), 0, 1, -1);
        run(enc(31, 1, 2, 3), 1, 1, -1);
        run(32'h18918000, 0, 2, -1);
        run(32'h18918000, 0, 0, 4);
        run(enc(15, 3, 3, 3), 2, 1, 2);

        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
            run(enc(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15))) | 32'($urandom_range(0, 32767)),
                w, 1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
